// File: rtl/spi_reg_access_ctrl_if.sv
//------------------------------------------------------------------------------
// spi_reg_access_ctrl_if : host request/response and SPI-master frame channels
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface spi_reg_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [6:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_err;
  logic [15:0] tx_data;
  logic        tx_data_en;
  logic        spi_ready;
  logic [7:0]  spi_rdata;
  logic        spi_rdata_vld;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  spi_ready, spi_rdata, spi_rdata_vld,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output tx_data, tx_data_en
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata,
    output spi_ready, spi_rdata, spi_rdata_vld,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  tx_data, tx_data_en
  );
endinterface

`default_nettype wire

// File: rtl/spi_reg_access_ctrl.sv
//------------------------------------------------------------------------------
// spi_reg_access_ctrl : single-register read/write requests -> 16-bit SPI frames
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_reg_access_ctrl #(
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                        clk,
  input  logic                        rst_n,
  spi_reg_access_ctrl_if.slave        bus
);

  typedef enum logic [2:0] {
    ST_GAP   = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_BUSY  = 3'd3,
    ST_DONE  = 3'd4,
    ST_RESP  = 3'd5
  } state_t;

  localparam logic [15:0] C_GAP     = 16'(GAP_CYC);
  localparam logic [15:0] C_TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q;
  logic [15:0] gap_q;
  logic [15:0] tcnt_q;
  logic        wr_q;
  logic [6:0]  addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rbuf_q;
  logic        got_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic [7:0]  resp_rdata_q;
  logic        resp_err_q;
  logic [15:0] tx_data_q;
  logic        tx_en_q;
  logic        timeout_hit;

  assign timeout_hit = (tcnt_q >= C_TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_GAP;
      gap_q        <= C_GAP;
      tcnt_q       <= 16'd0;
      wr_q         <= 1'b0;
      addr_q       <= 7'd0;
      wdata_q      <= 8'd0;
      rbuf_q       <= 8'd0;
      got_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 8'd0;
      resp_err_q   <= 1'b0;
      tx_data_q    <= 16'd0;
      tx_en_q      <= 1'b0;
    end else begin
      tx_en_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        ST_GAP: begin
          if (gap_q == 16'd0) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        ST_IDLE: begin
          if (bus.req_valid) begin
            wr_q        <= bus.req_wr;
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            got_q       <= 1'b0;
            tcnt_q      <= 16'd0;
            req_ready_q <= 1'b0;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_BUSY, ST_DONE: begin
          if (tcnt_q != 16'hFFFF) begin
            tcnt_q <= tcnt_q + 16'd1;
          end
          // The watchdog wins over any progress made in the same cycle.
          if (timeout_hit) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 8'd0;
            state_q      <= ST_RESP;
          end else begin
            case (state_q)
              ST_ISSUE: begin
                if (bus.spi_ready) begin
                  tx_en_q   <= 1'b1;
                  tx_data_q <= {wr_q, addr_q, wr_q ? wdata_q : 8'h00};
                  tcnt_q    <= 16'd0;
                  state_q   <= ST_BUSY;
                end
              end
              ST_BUSY: begin
                if (!bus.spi_ready) begin
                  state_q <= ST_DONE;
                end
              end
              default: begin
                if (wr_q) begin
                  if (bus.spi_ready) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 8'd0;
                    state_q      <= ST_RESP;
                  end
                end else begin
                  if (bus.spi_rdata_vld) begin
                    rbuf_q <= bus.spi_rdata;
                    got_q  <= 1'b1;
                  end
                  if (bus.spi_ready && (got_q || bus.spi_rdata_vld)) begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= bus.spi_rdata_vld ? bus.spi_rdata : rbuf_q;
                    state_q      <= ST_RESP;
                  end
                end
              end
            endcase
          end
        end
        ST_RESP: begin
          gap_q   <= C_GAP;
          state_q <= ST_GAP;
        end
        default: begin
          gap_q   <= C_GAP;
          state_q <= ST_GAP;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_data_en = tx_en_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_access_ctrl.sv
//------------------------------------------------------------------------------
// tb_spi_reg_access_ctrl : scoreboard bench with a register-file SPI master model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_spi_reg_access_ctrl;

  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 32;
  localparam int SPI_LEN     = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_reg_access_ctrl_if bus();

  spi_reg_access_ctrl #(
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] tx_q[$];
  logic [8:0]  resp_q[$];
  logic [7:0]  mem[128];
  bit spi_hang       = 1'b0;
  bit spi_force_busy = 1'b0;
  bit spi_same       = 1'b0;
  bit lat_chk        = 1'b1;
  int last_tx_cyc    = -1000;
  int last_resp_cyc  = -1000;
  int accept_cyc     = 0;
  bit outstanding    = 1'b0;
  bit tx_this        = 1'b0;
  bit rdy_hi         = 1'b0;
  logic prev_spi_ready = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on every DUT output event.
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 1'b0;
      tx_this     = 1'b0;
      rdy_hi      = 1'b0;
    end else begin
      if (outstanding && bus.req_ready) rdy_hi = 1'b1;
      if (bus.req_valid && bus.req_ready) begin
        accept_cyc  = cyc;
        outstanding = 1'b1;
        tx_this     = 1'b0;
        rdy_hi      = 1'b0;
      end
      if (bus.tx_data_en) begin
        chk("tx_expected", 32'(tx_q.size() != 0), 1);
        if (tx_q.size() != 0) chk("tx_data", bus.tx_data, tx_q.pop_front());
        chk("tx_spi_ready", prev_spi_ready, 1);
        chk("tx_gap", 32'((cyc - last_resp_cyc) >= GAP_CYC), 1);
        if (lat_chk) chk("tx_latency", cyc - accept_cyc, 2);
        last_tx_cyc = cyc;
        tx_this     = 1'b1;
      end
      if (bus.resp_valid) begin
        chk("resp_expected", 32'(resp_q.size() != 0), 1);
        if (resp_q.size() != 0) chk("resp_err_rdata", {bus.resp_err, bus.resp_rdata}, resp_q.pop_front());
        chk("req_ready_low", rdy_hi, 0);
        if (bus.resp_err && tx_this) chk("timeout_latency", cyc - last_tx_cyc, TIMEOUT_CYC);
        last_resp_cyc = cyc;
        outstanding   = 1'b0;
      end
    end
    prev_spi_ready = bus.spi_ready;
  end

  // SPI master model: register file, mem[a] = a*20 at start.
  initial begin : spi_model
    logic [15:0] fr;
    int n;
    for (int i = 0; i < 128; i++) mem[i] = 8'(i * 20);
    bus.spi_ready     = 1'b1;
    bus.spi_rdata     = 8'h00;
    bus.spi_rdata_vld = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.tx_data_en) begin
        fr = bus.tx_data;
        bus.spi_ready = 1'b0;
        repeat (SPI_LEN) begin @(posedge clk); #1; end
        n = 0;
        while (spi_hang && n < 2000) begin @(posedge clk); #1; n++; end
        if (fr[15]) mem[fr[14:8]] = fr[7:0];
        bus.spi_rdata     = fr[15] ? 8'hFF : mem[fr[14:8]];
        bus.spi_rdata_vld = 1'b1;
        if (spi_same) bus.spi_ready = 1'b1;
        @(posedge clk); #1;
        bus.spi_rdata_vld = 1'b0;
        bus.spi_ready     = 1'b1;
      end else begin
        bus.spi_ready = !spi_force_busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_txn(input bit has_tx, input logic [15:0] tx, input logic [8:0] resp);
    if (has_tx) tx_q.push_back(tx);
    resp_q.push_back(resp);
  endtask

  task automatic send(input bit wr, input logic [6:0] a, input logic [7:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("accept_wait", bus.req_ready, 1);
    tick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((resp_q.size() != 0 || outstanding) && n < 300) begin tick(); n++; end
    if (n >= 300) begin
      chk("resp_wait", 32'(resp_q.size()), 0);
      resp_q.delete();
      tx_q.delete();
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    int rel;
    int n;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = 7'd0;
    bus.req_wdata = 8'd0;
    repeat (3) tick();
    chk("rst_flags", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.tx_data_en}, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    rst_n = 1'b1;

    // Write 0x15 <- 0xA5, read 0x03, read back 0x15
    expect_txn(1, 16'h95A5, {1'b0, 8'h00});
    send(1, 7'h15, 8'hA5);
    bus.req_valid = 1'b0;
    wait_idle();
    expect_txn(1, 16'h0300, {1'b0, 8'h3C});
    send(0, 7'h03, 8'hFF);
    bus.req_valid = 1'b0;
    wait_idle();
    expect_txn(1, 16'h1500, {1'b0, 8'hA5});
    send(0, 7'h15, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();

    // Back-to-back with req_valid held high
    expect_txn(1, 16'hA111, {1'b0, 8'h00});
    expect_txn(1, 16'h2100, {1'b0, 8'h11});
    send(1, 7'h21, 8'h11);
    send(0, 7'h21, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();

    // rdata_vld and spi_ready rise together
    spi_same = 1'b1;
    expect_txn(1, 16'h0500, {1'b0, 8'h64});
    send(0, 7'h05, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();
    spi_same = 1'b0;

    // Read timeout, then late rdata_vld must not leak into the next read
    spi_hang = 1'b1;
    expect_txn(1, 16'h1000, {1'b1, 8'h00});
    send(0, 7'h10, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();
    spi_hang = 1'b0;
    expect_txn(1, 16'h1100, {1'b0, 8'h54});
    send(0, 7'h11, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();

    // Busy master briefly: issue waits for spi_ready
    lat_chk = 1'b0;
    spi_force_busy = 1'b1;
    repeat (2) tick();
    expect_txn(1, 16'h0300, {1'b0, 8'h3C});
    send(0, 7'h03, 8'h00);
    bus.req_valid = 1'b0;
    repeat (10) tick();
    spi_force_busy = 1'b0;
    wait_idle();

    // Busy master for 50 cycles: timeout without any frame
    spi_force_busy = 1'b1;
    repeat (2) tick();
    expect_txn(0, 16'h0000, {1'b1, 8'h00});
    send(0, 7'h03, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();
    repeat (20) tick();
    spi_force_busy = 1'b0;
    repeat (3) tick();
    lat_chk = 1'b1;

    // Reset while waiting in DONE
    spi_hang = 1'b1;
    tx_q.push_back(16'h0500);
    send(0, 7'h05, 8'h00);
    bus.req_valid = 1'b0;
    n = 0;
    while (tx_q.size() != 0 && n < 50) begin tick(); n++; end
    chk("reset_test_tx_seen", 32'(tx_q.size()), 0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.tx_data_en}, 0);
    chk("midrst_tx_data", bus.tx_data, 0);
    chk("midrst_resp_rdata", bus.resp_rdata, 0);
    spi_hang = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    rel = cyc;
    expect_txn(1, 16'h0500, {1'b0, 8'h64});
    send(0, 7'h05, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();
    chk("post_reset_gap", 32'((last_tx_cyc - rel) >= GAP_CYC + 2), 1);

    repeat (5) tick();
    chk("tx_q_drained", 32'(tx_q.size()), 0);
    chk("resp_q_drained", 32'(resp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
